framebuffer_fetch: RTL and testbench
====================================

Name: framebuffer_fetch

Overview:
- Sits directly downstream of matrix_scan and consumes its column_address, row_address, brightness_mask and clk_pixel_load.
- On each pixel-load event it reads the top-half and bottom-half pixels from a single-port framebuffer RAM.
- It reduces each colour channel against the current bit-plane mask and drives the panel's rgb1/rgb2 data lines.

Parameters:
- RAM_LATENCY, 1, cycles from ram_rd_en asserted to ram_rd_data valid (1..4).
- CHAN_WIDTH, 6, bits per colour channel; equals brightness_mask width.
- COL_BITS, 6, column address width (64 columns).
- ROW_BITS, 4, row address width (16 scan rows; panel has 32 rows).

Ports:
- clk_in  in  1  system clock; every flop uses this clock.
- reset  in  1  synchronous, active-high reset.
- clk_pixel_load  in  1  pixel-load strobe from matrix_scan, synchronous to clk_in; its rising edge starts a fetch.
- column_address  in  COL_BITS  column of the pixel to fetch.
- row_address  in  ROW_BITS  scan row; the top half uses this row, the bottom half uses this row + 16.
- brightness_mask  in  CHAN_WIDTH  bit-plane select, normally one-hot.
- ram_addr  out  1+ROW_BITS+COL_BITS  framebuffer address {half, row, col}.
- ram_rd_en  out  1  read strobe, one cycle per access.
- ram_rd_data  in  3*CHAN_WIDTH  pixel word {R, G, B}, R in the MSBs.
- rgb1  out  3  top-half {R, G, B} bit.
- rgb2  out  3  bottom-half {R, G, B} bit.
- pixel_valid  out  1  one-cycle pulse when rgb1/rgb2 update.
- overrun  out  1  sticky flag: a load edge arrived while busy.

Behaviour:
- Reset values: rgb1 = 0, rgb2 = 0, pixel_valid = 0, overrun = 0, ram_rd_en = 0, ram_addr = 0; FSM goes to IDLE and the edge-detect register is cleared to 0.
- Reset wins over every other event, including during a fetch. A fetch aborted by reset produces no pixel_valid.
- Edge detect: a registered copy of clk_pixel_load is kept. A rise is "load = 1 and prev = 0" sampled at clock edge N.
- Capture at edge N: column_address, row_address and brightness_mask are captured into working registers. Later input changes do not affect the fetch in flight.
- FSM states and transitions:
  - IDLE -> TOP_REQ on a rise.
  - TOP_REQ (1 cycle): ram_addr = {0, row, col}, ram_rd_en = 1. Then -> TOP_WAIT.
  - TOP_WAIT: stays RAM_LATENCY-1 cycles (0 when RAM_LATENCY = 1). The top word is captured at the edge RAM_LATENCY cycles after the TOP_REQ cycle.
  - BOT_REQ (1 cycle): ram_addr = {1, row, col}, ram_rd_en = 1. Then -> BOT_WAIT.
  - BOT_WAIT: waits the same way and captures the bottom word.
  - COMPOSE (1 cycle): rgb1/rgb2 are registered and pixel_valid = 1. Then -> IDLE.
- Latency: rgb1/rgb2/pixel_valid take their new values at edge N + 2*(RAM_LATENCY+1) + 1 (5 cycles for RAM_LATENCY = 1). The next rise is accepted in the cycle after COMPOSE.
- ram_rd_en is 0 outside the REQ states. ram_addr holds its last value when ram_rd_en is 0.
- Channel reduce: bit = |(channel & mask), computed per channel.
  - Multi-hot mask: the OR of all selected bits.
  - mask = 0: bit = 0.
- Bit order: rgb1 = {R, G, B} of the top word; rgb2 = the same for the bottom word.
- rgb1/rgb2 hold their values between pixel_valid pulses.
- Busy behaviour: a rise at any edge while the FSM is not IDLE is dropped (no queueing) and sets overrun = 1. overrun stays set until reset.
- A rise coincident with COMPOSE is also dropped.
- Row wrap: the bottom half uses half = 1 with the same row bits, so row 15 maps to address {1, 15, col}. No arithmetic carry is involved.

Decomposition:
- Shared package (matrix_pkg): COL_BITS, ROW_BITS, CHAN_WIDTH, pixel field offsets (R_MSB/R_LSB, G_MSB/G_LSB, B_MSB/B_LSB), HALF_TOP = 0 and HALF_BOT = 1, and the fetch FSM state encoding.
- One sub-module: bitplane_select. It is combinational: 3*CHAN_WIDTH word + mask -> 3-bit {R, G, B}. It is instantiated twice, for the top and bottom words.

Test Plan:
- Single fetch, RAM_LATENCY = 1, row 3, col 10, mask 6'b000100, top word R=6'h04 G=6'h00 B=6'h3F, bottom word all 6'h00 -> ram_addr 11'h0CA then 11'h4CA with ram_rd_en pulses; rgb1 = 3'b101, rgb2 = 3'b000; pixel_valid exactly 5 cycles after the edge.
- Mask 6'b000000 with all-ones RAM -> rgb1 = rgb2 = 0. Mask 6'b100001 with R=6'h01 -> R bit = 1.
- Second load rise 2 cycles after the first -> no extra ram_rd_en, overrun goes to 1 and stays 1 until reset; first pixel completes normally.
- Reset asserted in TOP_WAIT -> next cycle all outputs 0, no pixel_valid. A later load rise fetches normally.
- RAM_LATENCY = 3 rebuild -> pixel_valid 9 cycles after the rise; data captured from a model with 3-cycle read delay matches.
- Row 15, col 63 -> addresses 11'h3FF then 11'h7FF. Inputs changed mid-fetch do not alter either address.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix pipeline: geometry, pixel word layout,
// framebuffer half select and the fetch FSM encoding.
package matrix_pkg;

    localparam int COL_BITS   = 6;
    localparam int ROW_BITS   = 4;
    localparam int CHAN_WIDTH = 6;

    localparam int WORD_BITS = 3 * CHAN_WIDTH;
    localparam int ADDR_BITS = 1 + ROW_BITS + COL_BITS;

    // Pixel word is {R, G, B} with R in the MSBs.
    localparam int R_MSB = 3 * CHAN_WIDTH - 1;
    localparam int R_LSB = 2 * CHAN_WIDTH;
    localparam int G_MSB = 2 * CHAN_WIDTH - 1;
    localparam int G_LSB = CHAN_WIDTH;
    localparam int B_MSB = CHAN_WIDTH - 1;
    localparam int B_LSB = 0;

    localparam logic HALF_TOP = 1'b0;
    localparam logic HALF_BOT = 1'b1;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE     = 3'd0;
    localparam fetch_state_t FETCH_TOP_REQ  = 3'd1;
    localparam fetch_state_t FETCH_TOP_WAIT = 3'd2;
    localparam fetch_state_t FETCH_BOT_REQ  = 3'd3;
    localparam fetch_state_t FETCH_BOT_WAIT = 3'd4;
    localparam fetch_state_t FETCH_COMPOSE  = 3'd5;

    typedef struct packed {
        logic [ROW_BITS-1:0]   row;
        logic [COL_BITS-1:0]   col;
        logic [CHAN_WIDTH-1:0] mask;
    } fetch_req_t;

    function automatic logic [ADDR_BITS-1:0] fb_addr(
        input logic                half,
        input logic [ROW_BITS-1:0] row,
        input logic [COL_BITS-1:0] col
    );
        return {half, row, col};
    endfunction

endpackage

// File: rtl/bitplane_select.sv
// Reduces one {R, G, B} pixel word to a single bit per channel for the
// bit-plane currently being shown.
module bitplane_select
    import matrix_pkg::*;
(
    input  logic [WORD_BITS-1:0]  word_i,
    input  logic [CHAN_WIDTH-1:0] mask_i,
    output logic [2:0]            rgb_o
);

    logic [CHAN_WIDTH-1:0] red;
    logic [CHAN_WIDTH-1:0] green;
    logic [CHAN_WIDTH-1:0] blue;

    assign red   = word_i[R_MSB:R_LSB];
    assign green = word_i[G_MSB:G_LSB];
    assign blue  = word_i[B_MSB:B_LSB];

    // A multi-hot mask ORs the selected planes; an empty mask yields 0.
    assign rgb_o = {|(red & mask_i), |(green & mask_i), |(blue & mask_i)};

endmodule

// File: rtl/framebuffer_fetch.sv
// On each pixel-load rising edge, reads the top- and bottom-half pixels from a
// single-port framebuffer and drives one bit-plane of each onto rgb1/rgb2.
module framebuffer_fetch
    import matrix_pkg::*;
#(
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  clk_pixel_load,
    input  logic [COL_BITS-1:0]   column_address,
    input  logic [ROW_BITS-1:0]   row_address,
    input  logic [CHAN_WIDTH-1:0] brightness_mask,
    output logic [ADDR_BITS-1:0]  ram_addr,
    output logic                  ram_rd_en,
    input  logic [WORD_BITS-1:0]  ram_rd_data,
    output logic [2:0]            rgb1,
    output logic [2:0]            rgb2,
    output logic                  pixel_valid,
    output logic                  overrun
);

    // Last WAIT cycle; the read word is sampled at the end of it.
    localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 1);

    fetch_state_t          state_q, state_d;
    logic                  load_prev_q;
    logic                  load_rise;
    fetch_req_t            req_q, req_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic [WORD_BITS-1:0]  top_word_q, top_word_d;
    logic [WORD_BITS-1:0]  bot_word_q, bot_word_d;
    logic [ADDR_BITS-1:0]  ram_addr_q, ram_addr_d;
    logic                  ram_rd_en_q, ram_rd_en_d;
    logic [2:0]            rgb1_q, rgb1_d;
    logic [2:0]            rgb2_q, rgb2_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  overrun_q, overrun_d;
    logic [2:0]            top_rgb;
    logic [2:0]            bot_rgb;

    assign load_rise = clk_pixel_load & ~load_prev_q;

    bitplane_select u_sel_top (
        .word_i (top_word_q),
        .mask_i (req_q.mask),
        .rgb_o  (top_rgb)
    );

    bitplane_select u_sel_bot (
        .word_i (bot_word_q),
        .mask_i (req_q.mask),
        .rgb_o  (bot_rgb)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        wait_cnt_d    = wait_cnt_q;
        top_word_d    = top_word_q;
        bot_word_d    = bot_word_q;
        ram_addr_d    = ram_addr_q;
        ram_rd_en_d   = 1'b0;
        rgb1_d        = rgb1_q;
        rgb2_d        = rgb2_q;
        pixel_valid_d = 1'b0;
        overrun_d     = overrun_q;

        // Fetches are never queued: any rise outside IDLE is lost and flagged.
        if (load_rise && (state_q != FETCH_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            FETCH_IDLE: begin
                if (load_rise) begin
                    req_d.row   = row_address;
                    req_d.col   = column_address;
                    req_d.mask  = brightness_mask;
                    ram_addr_d  = fb_addr(HALF_TOP, row_address, column_address);
                    ram_rd_en_d = 1'b1;
                    state_d     = FETCH_TOP_REQ;
                end
            end
            FETCH_TOP_REQ: begin
                wait_cnt_d = 2'd0;
                state_d    = FETCH_TOP_WAIT;
            end
            FETCH_TOP_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    top_word_d  = ram_rd_data;
                    ram_addr_d  = fb_addr(HALF_BOT, req_q.row, req_q.col);
                    ram_rd_en_d = 1'b1;
                    state_d     = FETCH_BOT_REQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            FETCH_BOT_REQ: begin
                wait_cnt_d = 2'd0;
                state_d    = FETCH_BOT_WAIT;
            end
            FETCH_BOT_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    bot_word_d = ram_rd_data;
                    state_d    = FETCH_COMPOSE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            FETCH_COMPOSE: begin
                rgb1_d        = top_rgb;
                rgb2_d        = bot_rgb;
                pixel_valid_d = 1'b1;
                state_d       = FETCH_IDLE;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= FETCH_IDLE;
            load_prev_q   <= 1'b0;
            req_q         <= '0;
            wait_cnt_q    <= 2'd0;
            top_word_q    <= '0;
            bot_word_q    <= '0;
            ram_addr_q    <= '0;
            ram_rd_en_q   <= 1'b0;
            rgb1_q        <= 3'd0;
            rgb2_q        <= 3'd0;
            pixel_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_prev_q   <= clk_pixel_load;
            req_q         <= req_d;
            wait_cnt_q    <= wait_cnt_d;
            top_word_q    <= top_word_d;
            bot_word_q    <= bot_word_d;
            ram_addr_q    <= ram_addr_d;
            ram_rd_en_q   <= ram_rd_en_d;
            rgb1_q        <= rgb1_d;
            rgb2_q        <= rgb2_d;
            pixel_valid_q <= pixel_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign rgb1        = rgb1_q;
    assign rgb2        = rgb2_q;
    assign pixel_valid = pixel_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_framebuffer_fetch.sv
// Bench for framebuffer_fetch: one instance at RAM latency 1 and one at 3, each
// fed by a framebuffer model, with address/pixel/latency scoreboards.
module tb_framebuffer_fetch;
    import matrix_pkg::*;

    localparam logic [17:0] POISON = 18'h15555;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        load1, load3;
    logic [5:0]  col;
    logic [3:0]  row;
    logic [5:0]  mask;

    logic [10:0] addr1, addr3;
    logic        rd_en1, rd_en3;
    logic [17:0] rdata1, rdata3;
    logic [2:0]  rgb1_1, rgb2_1, rgb1_3, rgb2_3;
    logic        pv1, pv3, ov1, ov3;

    logic [17:0] mem [0:2047];
    logic [17:0] p3 [0:2];

    logic [10:0] addr1_q[$];
    logic [10:0] addr3_q[$];
    logic [5:0]  pix1_q[$];
    logic [5:0]  pix3_q[$];
    int          lat1_q[$];
    int          lat3_q[$];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    framebuffer_fetch #(.RAM_LATENCY(1)) u_dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .clk_pixel_load  (load1),
        .column_address  (col),
        .row_address     (row),
        .brightness_mask (mask),
        .ram_addr        (addr1),
        .ram_rd_en       (rd_en1),
        .ram_rd_data     (rdata1),
        .rgb1            (rgb1_1),
        .rgb2            (rgb2_1),
        .pixel_valid     (pv1),
        .overrun         (ov1)
    );

    framebuffer_fetch #(.RAM_LATENCY(3)) u_dut_l3 (
        .clk_in          (clk_in),
        .reset           (reset),
        .clk_pixel_load  (load3),
        .column_address  (col),
        .row_address     (row),
        .brightness_mask (mask),
        .ram_addr        (addr3),
        .ram_rd_en       (rd_en3),
        .ram_rd_data     (rdata3),
        .rgb1            (rgb1_3),
        .rgb2            (rgb2_3),
        .pixel_valid     (pv3),
        .overrun         (ov3)
    );

    // Framebuffer models: data is valid to be sampled RAM_LATENCY edges after
    // the edge that sees ram_rd_en; otherwise a poison pattern is shown.
    always @(posedge clk_in) rdata1 <= rd_en1 ? mem[addr1] : POISON;

    always @(posedge clk_in) begin
        p3[0] <= rd_en3 ? mem[addr3] : POISON;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata3 = p3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_px(input logic [17:0] tw, input logic [17:0] bw,
                                          input logic [5:0] m);
        logic [5:0] p;
        p = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int b = 0; b < 6; b++) begin
                if (m[b] && tw[12 - 6*ch + b]) p[5 - ch] = 1'b1;
                if (m[b] && bw[12 - 6*ch + b]) p[2 - ch] = 1'b1;
            end
        end
        return p;
    endfunction

    always @(negedge clk_in) begin
        if (rd_en1) begin
            chk("rd_en1_expected", 32'(addr1_q.size() != 0), 32'd1);
            if (addr1_q.size() != 0) chk("ram_addr1", 32'(addr1), 32'(addr1_q.pop_front()));
        end
        if (pv1) begin
            chk("pv1_expected", 32'(pix1_q.size() != 0), 32'd1);
            if (pix1_q.size() != 0) begin
                chk("pixel1", 32'({rgb1_1, rgb2_1}), 32'(pix1_q.pop_front()));
                chk("latency1", 32'(cyc), 32'(lat1_q.pop_front()));
            end
        end
        if (rd_en3) begin
            chk("rd_en3_expected", 32'(addr3_q.size() != 0), 32'd1);
            if (addr3_q.size() != 0) chk("ram_addr3", 32'(addr3), 32'(addr3_q.pop_front()));
        end
        if (pv3) begin
            chk("pv3_expected", 32'(pix3_q.size() != 0), 32'd1);
            if (pix3_q.size() != 0) begin
                chk("pixel3", 32'({rgb1_3, rgb2_3}), 32'(pix3_q.pop_front()));
                chk("latency3", 32'(cyc), 32'(lat3_q.pop_front()));
            end
        end
    end

    // Called just after a falling edge; the rise is sampled at the next edge.
    task automatic fetch1(input logic [3:0] r, input logic [5:0] c, input logic [5:0] m,
                          input logic [17:0] tw, input logic [17:0] bw, input logic [5:0] exp_px);
        mem[{1'b0, r, c}] = tw;
        mem[{1'b1, r, c}] = bw;
        row = r; col = c; mask = m; load1 = 1'b1;
        addr1_q.push_back({1'b0, r, c});
        addr1_q.push_back({1'b1, r, c});
        pix1_q.push_back(exp_px);
        lat1_q.push_back(cyc + 6);
        @(negedge clk_in);
        load1 = 1'b0;
    endtask

    task automatic fetch3(input logic [3:0] r, input logic [5:0] c, input logic [5:0] m,
                          input logic [17:0] tw, input logic [17:0] bw, input logic [5:0] exp_px);
        mem[{1'b0, r, c}] = tw;
        mem[{1'b1, r, c}] = bw;
        row = r; col = c; mask = m; load3 = 1'b1;
        addr3_q.push_back({1'b0, r, c});
        addr3_q.push_back({1'b1, r, c});
        pix3_q.push_back(exp_px);
        lat3_q.push_back(cyc + 10);
        @(negedge clk_in);
        load3 = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (pix1_q.size() + addr1_q.size() + pix3_q.size()
                                       + addr3_q.size()) != 0; i++) begin
            @(negedge clk_in);
        end
        chk("drain_pending", 32'(pix1_q.size() + addr1_q.size() + pix3_q.size()
                                 + addr3_q.size()), 32'd0);
    endtask

    initial begin
        logic [3:0]  rr;
        logic [5:0]  cc, mm;
        logic [17:0] tw, bw;

        reset = 1'b1; load1 = 1'b0; load3 = 1'b0;
        row = '0; col = '0; mask = '0;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        for (int i = 0; i < 3; i++) p3[i] = POISON;

        repeat (3) @(negedge clk_in);
        chk("reset_rgb1", 32'(rgb1_1), 32'd0);
        chk("reset_rgb2", 32'(rgb2_1), 32'd0);
        chk("reset_pv", 32'(pv1), 32'd0);
        chk("reset_overrun", 32'(ov1), 32'd0);
        chk("reset_rd_en", 32'(rd_en1), 32'd0);
        chk("reset_addr", 32'(addr1), 32'd0);
        reset = 1'b0;
        @(negedge clk_in);

        // Single fetch: addresses 0CA then 4CA, rgb1=101, rgb2=000.
        fetch1(4'd3, 6'd10, 6'b000100, {6'h04, 6'h00, 6'h3F}, 18'h0, 6'b101_000);
        wait_drain(20);

        fetch1(4'd5, 6'd20, 6'b000000, 18'h3FFFF, 18'h3FFFF, 6'b000_000);
        wait_drain(20);

        fetch1(4'd6, 6'd7, 6'b100001, {6'h01, 6'h00, 6'h00}, {6'h20, 6'h3F, 6'h00}, 6'b100_110);
        wait_drain(20);

        for (int i = 0; i < 4; i++) begin
            rr = 4'($urandom_range(0, 15));
            cc = 6'($urandom_range(0, 63));
            mm = (i == 3) ? 6'($urandom_range(0, 63)) : 6'(1 << $urandom_range(0, 5));
            tw = 18'($urandom);
            bw = 18'($urandom);
            fetch1(rr, cc, mm, tw, bw, ref_px(tw, bw, mm));
            wait_drain(20);
        end

        // Row 15 / col 63, with inputs changed while the fetch is in flight.
        fetch1(4'd15, 6'd63, 6'b010000, {6'h10, 6'h0F, 6'h30}, {6'h00, 6'h3F, 6'h10}, 6'b101_011);
        row = 4'd2; col = 6'd5; mask = 6'b000001;
        wait_drain(20);

        // Back-to-back: second rise lands the cycle after COMPOSE and is accepted.
        fetch1(4'd1, 6'd1, 6'b000010, {6'h02, 6'h02, 6'h00}, 18'h0, 6'b110_000);
        repeat (5) @(negedge clk_in);
        fetch1(4'd1, 6'd2, 6'b000001, 18'h0, {6'h01, 6'h00, 6'h01}, 6'b000_101);
        wait_drain(30);
        chk("overrun_back_to_back", 32'(ov1), 32'd0);

        // Second rise two cycles after the first is dropped and flags overrun.
        fetch1(4'd7, 6'd33, 6'b001000, {6'h3F, 6'h00, 6'h08}, {6'h08, 6'h08, 6'h08}, 6'b101_111);
        @(negedge clk_in);
        load1 = 1'b1;
        @(negedge clk_in);
        load1 = 1'b0;
        chk("overrun_set", 32'(ov1), 32'd1);
        wait_drain(20);
        repeat (4) @(negedge clk_in);
        chk("overrun_sticky", 32'(ov1), 32'd1);

        // Reset during TOP_WAIT aborts the fetch.
        fetch1(4'd9, 6'd17, 6'b000001, 18'h3FFFF, 18'h3FFFF, 6'b111_111);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        chk("abort_rgb1", 32'(rgb1_1), 32'd0);
        chk("abort_rgb2", 32'(rgb2_1), 32'd0);
        chk("abort_pv", 32'(pv1), 32'd0);
        chk("abort_overrun", 32'(ov1), 32'd0);
        chk("abort_rd_en", 32'(rd_en1), 32'd0);
        chk("abort_addr", 32'(addr1), 32'd0);
        addr1_q.delete(); pix1_q.delete(); lat1_q.delete();
        reset = 1'b0;
        repeat (10) @(negedge clk_in);
        fetch1(4'd9, 6'd17, 6'b000010, {6'h02, 6'h00, 6'h02}, {6'h00, 6'h02, 6'h00}, 6'b101_010);
        wait_drain(20);

        // A rise coincident with COMPOSE is dropped.
        chk("overrun_clear", 32'(ov1), 32'd0);
        fetch1(4'd12, 6'd40, 6'b000100, {6'h04, 6'h04, 6'h04}, {6'h00, 6'h04, 6'h00}, 6'b111_010);
        repeat (4) @(negedge clk_in);
        load1 = 1'b1;
        @(negedge clk_in);
        load1 = 1'b0;
        chk("overrun_compose", 32'(ov1), 32'd1);
        wait_drain(20);
        repeat (8) @(negedge clk_in);

        // Three-cycle RAM instance.
        fetch3(4'd4, 6'd50, 6'b100000, {6'h20, 6'h1F, 6'h3F}, {6'h3F, 6'h20, 6'h00}, 6'b101_110);
        wait_drain(40);
        fetch3(4'd11, 6'd3, 6'b101010, {6'h02, 6'h01, 6'h08}, {6'h00, 6'h15, 6'h20}, 6'b101_001);
        wait_drain(40);
        chk("overrun_l3", 32'(ov3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
